// File: rtl/game_time_counter.sv
// rtl/game_time_counter.sv - countdown game clock: 1 s prescaler, IDLE/RUN/PAUSE/EXPIRED FSM, bonus time
// Optional registered lowTimeWarn output is built only when LOW_TIME_WARN_EN is defined.
module game_time_counter #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter logic [11:0] START_SEC     = 12'd60,
  parameter logic [11:0] BONUS_SEC     = 12'd5,
  parameter logic [11:0] MAX_SEC       = 12'd4095
`ifdef LOW_TIME_WARN_EN
  ,
  parameter logic [11:0] WARN_SEC      = 12'd10
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startGame,
  input  logic        pauseToggle,
  input  logic        addBonus,
  output logic [11:0] gameTime,
  output logic        running,
  output logic        oneSecTick,
  output logic        timeUp,
  output logic        lowTimeWarn
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   prescaler_q, prescaler_d;
  logic [11:0]     game_time_q, game_time_d;
  logic            running_q, running_d;
  logic            time_up_q, time_up_d;

  logic            tick;
  logic            bonus_ok;
  logic            dec;
  logic            expire;
  logic [12:0]     sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (startGame) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (expire) begin
            state_d = EXPIRED;
          end else if (pauseToggle) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (pauseToggle) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_comb begin
    tick      = (state_q == RUN) && (prescaler_q == PRE_MAX);
    running_d = (state_d == RUN);
  end

  // Decrement and bonus share one 13-bit update so a bonus on the last tick prevents expiry.
  always_comb begin
    bonus_ok    = addBonus && ((state_q == RUN) || (state_q == PAUSE));
    dec         = tick && (game_time_q != 12'd0);
    sum         = {1'b0, game_time_q} - {12'd0, dec} + {1'b0, BONUS_SEC};
    expire      = tick && !bonus_ok && (game_time_q <= 12'd1);
    game_time_d = game_time_q;
    prescaler_d = prescaler_q;
    time_up_d   = 1'b0;
    if (startGame) begin
      game_time_d = START_SEC;
      prescaler_d = '0;
    end else begin
      case (state_q)
        RUN:     prescaler_d = tick ? '0 : prescaler_q + PW'(1);
        PAUSE:   prescaler_d = prescaler_q;
        default: prescaler_d = '0;
      endcase
      if (bonus_ok) begin
        game_time_d = (sum > {1'b0, MAX_SEC}) ? MAX_SEC : sum[11:0];
      end else if (dec) begin
        game_time_d = game_time_q - 12'd1;
      end
      time_up_d = expire;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      game_time_q <= 12'd0;
      prescaler_q <= '0;
      running_q   <= 1'b0;
      time_up_q   <= 1'b0;
    end else begin
      game_time_q <= game_time_d;
      prescaler_q <= prescaler_d;
      running_q   <= running_d;
      time_up_q   <= time_up_d;
    end
  end

  assign gameTime   = game_time_q;
  assign running    = running_q;
  assign oneSecTick = tick;
  assign timeUp     = time_up_q;

`ifdef LOW_TIME_WARN_EN
  logic low_time_warn_q, low_time_warn_d;

  always_comb begin
    low_time_warn_d = ((state_q == RUN) || (state_q == PAUSE)) &&
                      (game_time_q != 12'd0) && (game_time_q <= WARN_SEC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      low_time_warn_q <= 1'b0;
    end else begin
      low_time_warn_q <= low_time_warn_d;
    end
  end

  assign lowTimeWarn = low_time_warn_q;
`else
  assign lowTimeWarn = 1'b0;
`endif

endmodule
